// File: rtl/cache_ctrl_burst_if.sv
// cache_ctrl_burst_if
//   Groups the CPU request handshake, tag/data array strobes and the burst
//   memory port of cache_ctrl_burst.
//   Ports (modport slave = controller view):
//     req_valid, req_write   in   CPU request present / request is a store
//     req_ready              out  controller idle, can accept
//     hit, dirty             in   tag compare result / victim line dirty
//     mem_rd, mem_wr         out  refill read / write-back write beat request
//     mem_beat_addr          out  word index of the current beat in the block
//     mem_ack                in   current beat accepted/returned this cycle
//     fill_we, tag_we        out  data array write / tag update strobes
//     resp_valid             out  one-cycle request-complete pulse
//   Modport master is the CPU/array/memory side of the same signals.
interface cache_ctrl_burst_if #(
    parameter int BLOCK_WORDS = 4
);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);

    logic              req_valid;
    logic              req_write;
    logic              req_ready;
    logic              hit;
    logic              dirty;
    logic              mem_rd;
    logic              mem_wr;
    logic [BEAT_W-1:0] mem_beat_addr;
    logic              mem_ack;
    logic              fill_we;
    logic              tag_we;
    logic              resp_valid;

    modport slave (
        input  req_valid, req_write, hit, dirty, mem_ack,
        output req_ready, mem_rd, mem_wr, mem_beat_addr, fill_we, tag_we, resp_valid
    );

    modport master (
        output req_valid, req_write, hit, dirty, mem_ack,
        input  req_ready, mem_rd, mem_wr, mem_beat_addr, fill_we, tag_we, resp_valid
    );
endinterface

// File: rtl/cache_ctrl_burst.sv
// cache_ctrl_burst
//   Multi-beat cache controller FSM. Accepts one CPU request at a time, samples
//   the tag-compare hit, refills a miss as BLOCK_WORDS memory beats and keeps
//   saturating access/hit/miss counters.
//   Build option: define CACHE_WB_EN to write back a dirty victim (WB state)
//   before the refill. Without it the WB state does not exist, dirty is ignored
//   and mem_wr is constant 0.
//   Ports:
//     clk          in   rising-edge clock
//     rst          in   asynchronous active-low reset
//     bus          slave modport of cache_ctrl_burst_if (request/array/memory)
//     cnt_clr      in   synchronous clear of all counters (wins over increments)
//     access_cnt   out  accepted requests (saturating)
//     hit_cnt      out  hits (saturating)
//     miss_cnt     out  misses (saturating)
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | req_ready=1, waiting for req_valid
//   S_LOOKUP | one cycle, samples hit (and dirty when write-back is built in)
//   S_WB     | victim write-back, one mem_wr beat per mem_ack
//   S_REFILL | line refill, one mem_rd beat per mem_ack, tag_we on last beat
//   S_RESP   | resp_valid for one cycle, back to idle
module cache_ctrl_burst #(
    parameter int CNT_W       = 15,
    parameter int BLOCK_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_ctrl_burst_if.slave    bus,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     access_cnt,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic [CNT_W-1:0]     miss_cnt
);
    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);

`ifdef CACHE_WB_EN
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_WB, S_REFILL, S_RESP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_t;
`endif

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] beat, beat_nxt;
    logic              acc_inc, hit_inc, miss_inc;

    // req_write is informational only; dirty is unused without write-back.
    logic unused_inputs;
    assign unused_inputs = ^{bus.req_write, bus.dirty};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            beat       <= '0;
            access_cnt <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            state <= state_nxt;
            beat  <= beat_nxt;
            if (cnt_clr) begin
                access_cnt <= '0;
                hit_cnt    <= '0;
                miss_cnt   <= '0;
            end else begin
                access_cnt <= sat_inc(access_cnt, acc_inc);
                hit_cnt    <= sat_inc(hit_cnt, hit_inc);
                miss_cnt   <= sat_inc(miss_cnt, miss_inc);
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        beat_nxt       = beat;
        acc_inc        = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        bus.req_ready  = 1'b0;
        bus.mem_rd     = 1'b0;
        bus.mem_wr     = 1'b0;
        bus.fill_we    = 1'b0;
        bus.tag_we     = 1'b0;
        bus.resp_valid = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nxt = S_LOOKUP;
                    acc_inc   = 1'b1;
                end
            end
            S_LOOKUP: begin
                if (bus.hit) begin
                    state_nxt = S_RESP;
                    hit_inc   = 1'b1;
                end else begin
                    miss_inc  = 1'b1;
                    beat_nxt  = '0;
`ifdef CACHE_WB_EN
                    state_nxt = bus.dirty ? S_WB : S_REFILL;
`else
                    state_nxt = S_REFILL;
`endif
                end
            end
`ifdef CACHE_WB_EN
            S_WB: begin
                bus.mem_wr = 1'b1;
                if (bus.mem_ack) begin
                    // Beat counter wraps to 0 on the last beat, ready for refill.
                    beat_nxt = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_nxt = S_REFILL;
                    end
                end
            end
`endif
            S_REFILL: begin
                bus.mem_rd = 1'b1;
                if (bus.mem_ack) begin
                    bus.fill_we = 1'b1;
                    beat_nxt    = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        bus.tag_we = 1'b1;
                        state_nxt  = S_RESP;
                    end
                end
            end
            S_RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.mem_beat_addr = beat;
endmodule

// File: tb/tb_cache_ctrl_burst.sv
module tb_cache_ctrl_burst;
    localparam int CNT_W = 3;
    localparam int BW    = 4;
    localparam int SAT   = 7;
`ifdef CACHE_WB_EN
    localparam bit WB_EN = 1'b1;
`else
    localparam bit WB_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cnt_clr = 1'b0;
    logic [CNT_W-1:0] access_cnt, hit_cnt, miss_cnt;

    cache_ctrl_burst_if #(.BLOCK_WORDS(BW)) bus ();

    cache_ctrl_burst #(.CNT_W(CNT_W), .BLOCK_WORDS(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus.slave),
        .cnt_clr    (cnt_clr),
        .access_cnt (access_cnt),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        bit       wr;
        bit [1:0] addr;
    } beat_t;

    typedef struct {
        bit h;
        bit d;
        int gap;
        bit spur;
        bit hold;
        int lat;
    } vec_t;

    int    errors = 0;
    int    checks = 0;
    beat_t beat_q[$];
    int    lat_q[$];
    int    m_acc = 0, m_hit = 0, m_miss = 0;
    vec_t  vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    function automatic int miss_lat(input bit d, input int gap);
        int nb;
        nb = (d && WB_EN) ? 2 * BW : BW;
        return 2 + nb * (gap + 1);
    endfunction

    task automatic check_counters(input string tag);
        chk({tag, "_access"}, int'(access_cnt), m_acc);
        chk({tag, "_hit"},    int'(hit_cnt),    m_hit);
        chk({tag, "_miss"},   int'(miss_cnt),   m_miss);
    endtask

    // Drives one request from IDLE and follows it cycle by cycle to resp_valid.
    task automatic run_req(input vec_t v, input bit clr);
        int    k;
        int    wc;
        bit    busy, ack, exp_resp, exp_fill;
        beat_t f;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = v.d;
        bus.hit       = v.h;
        bus.dirty     = v.d;
        bus.mem_ack   = 1'b0;
        cnt_clr       = clr;
        #1;
        chk("ready_at_accept", int'(bus.req_ready), 1);
        if (!v.h) begin
            if (v.d && WB_EN)
                for (int i = 0; i < BW; i++) beat_q.push_back('{wr: 1'b1, addr: 2'(i)});
            for (int i = 0; i < BW; i++) beat_q.push_back('{wr: 1'b0, addr: 2'(i)});
        end
        lat_q.push_back(v.lat);
        if (clr) begin
            m_acc = 0; m_hit = 0; m_miss = 0;
        end else begin
            m_acc = sat(m_acc);
            if (v.h) m_hit = sat(m_hit);
            else     m_miss = sat(m_miss);
        end
        k  = 0;
        wc = 0;
        exp_resp = 1'b0;
        while (!exp_resp) begin
            @(negedge clk);
            k++;
            if (!v.hold) bus.req_valid = 1'b0;
            busy = (k >= 2) && (beat_q.size() > 0);
            f    = busy ? beat_q[0] : '0;
            ack  = busy ? (wc >= v.gap) : v.spur;
            bus.mem_ack = ack;
            #1;
            exp_fill = busy && ack && !f.wr;
            exp_resp = (k >= 2) && !busy;
            chk("req_ready_busy", int'(bus.req_ready), 0);
            chk("mem_rd",  int'(bus.mem_rd), int'(busy && !f.wr));
            chk("mem_wr",  int'(bus.mem_wr), int'(busy && f.wr));
            if (busy) chk("beat_addr", int'(bus.mem_beat_addr), int'(f.addr));
            chk("fill_we", int'(bus.fill_we), int'(exp_fill));
            chk("tag_we",  int'(bus.tag_we),  int'(exp_fill && (f.addr == 2'(BW - 1))));
            chk("resp_valid", int'(bus.resp_valid), int'(exp_resp));
            if (exp_resp) chk("latency", k, lat_q.pop_front());
            if (busy && ack) begin
                void'(beat_q.pop_front());
                wc = 0;
            end else if (busy) begin
                wc++;
            end
        end
        bus.req_valid = 1'b0;
        bus.mem_ack   = 1'b0;
        bus.hit       = 1'b0;
        bus.dirty     = 1'b0;
        cnt_clr       = 1'b0;
        @(negedge clk);
        #1;
        chk("ready_after", int'(bus.req_ready), 1);
        chk("resp_after",  int'(bus.resp_valid), 0);
        check_counters("cnt");
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"},  int'(bus.req_ready), 1);
        chk({tag, "_mem_rd"}, int'(bus.mem_rd), 0);
        chk({tag, "_mem_wr"}, int'(bus.mem_wr), 0);
        chk({tag, "_addr"},   int'(bus.mem_beat_addr), 0);
        chk({tag, "_fill"},   int'(bus.fill_we), 0);
        chk({tag, "_tag"},    int'(bus.tag_we), 0);
        chk({tag, "_resp"},   int'(bus.resp_valid), 0);
        chk({tag, "_access"}, int'(access_cnt), 0);
        chk({tag, "_hit"},    int'(hit_cnt), 0);
        chk({tag, "_miss"},   int'(miss_cnt), 0);
    endtask

    initial begin
        vec_t hv;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.hit       = 1'b0;
        bus.dirty     = 1'b0;
        bus.mem_ack   = 1'b0;

        //          hit   dirty gap spur  hold  latency
        vecs[0] = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 2};
        vecs[1] = '{1'b0, 1'b0, 0, 1'b1, 1'b0, miss_lat(1'b0, 0)};
        vecs[2] = '{1'b0, 1'b1, 2, 1'b0, 1'b0, miss_lat(1'b1, 2)};
        vecs[3] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 2};
        vecs[4] = '{1'b0, 1'b0, 1, 1'b0, 1'b1, miss_lat(1'b0, 1)};
        vecs[5] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, miss_lat(1'b1, 0)};
        vecs[6] = '{1'b1, 1'b0, 0, 1'b0, 1'b1, 2};
        hv      = '{1'b1, 1'b0, 0, 1'b0, 1'b0, 2};

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;

        foreach (vecs[i]) run_req(vecs[i], 1'b0);

        // Saturation: counters stick at all-ones.
        for (int i = 0; i < 9; i++) run_req(hv, 1'b0);
        // Clear held through a hit: clear wins over the increments.
        run_req(hv, 1'b1);
        run_req(hv, 1'b0);

        // Reset in the middle of a stalled refill.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.hit       = 1'b0;
        bus.dirty     = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("stall_mem_rd", int'(bus.mem_rd), 1);
            chk("stall_addr",   int'(bus.mem_beat_addr), 0);
            chk("stall_fill",   int'(bus.fill_we), 0);
        end
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        m_acc = 0; m_hit = 0; m_miss = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("post_rst_resp",  int'(bus.resp_valid), 0);
            chk("post_rst_tag",   int'(bus.tag_we), 0);
            chk("post_rst_ready", int'(bus.req_ready), 1);
        end
        run_req(hv, 1'b0);
        run_req(vecs[1], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end
endmodule
